fault_locate_correct: RTL and testbench

- Sits directly downstream of the column checksum verifier in the fault-tolerant matrix-multiply accelerator.
- Latches the verifier's 33-bit column indicator, then takes the full-encoded result matrix Cf one row at a time. Each row is N data elements plus one row-checksum element.
- For every row it recomputes the row checksum and combines a row mismatch with the latched column indicator to locate a single faulty element. It corrects that element in place and streams the row out.
- Per-run results reported: a corrected-element count and a sticky uncorrectable flag.

---
 rtl/fault_locate_correct_pkg.sv | 24 ++
 rtl/fault_locate_correct_row_checksum_adder.sv | 18 +
 rtl/fault_locate_correct.sv | 134 +++++++++++++
 tb/tb_fault_locate_correct.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_locate_correct_pkg.sv
// rtl/fault_locate_correct_pkg.sv - shared parameters, state encoding and indicator popcount
package fault_locate_correct_pkg;

  localparam int N_DEF  = 32;
  localparam int W_DEF  = 32;
  localparam int ELEM_W = W_DEF;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_WAIT_ROW = 3'd2;
  localparam logic [2:0] S_SUM      = 3'd3;
  localparam logic [2:0] S_FIX      = 3'd4;
  localparam logic [2:0] S_OUT      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  // Number of flagged columns; callers zero-extend the indicator to 64 bits.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/fault_locate_correct_row_checksum_adder.sv
// rtl/fault_locate_correct_row_checksum_adder.sv - combinational modulo-2^W sum of the N data elements of a row
module row_checksum_adder
  import fault_locate_correct_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic [N*W-1:0] elems_i,
  output logic [W-1:0]   sum_o
);

  // Wrap-around is intended: the checksum is defined modulo 2^W.
  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N; k++) sum_o = sum_o + elems_i[k*W +: W];
  end

endmodule

// File: rtl/fault_locate_correct.sv
// rtl/fault_locate_correct.sv - per-row checksum recompute, single-fault location and in-place correction
module fault_locate_correct
  import fault_locate_correct_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N:0]           column_indicator,
  input  logic                 column_verify_ready,
  input  logic                 abort,
  input  logic [(N+1)*W-1:0]   row_in,
  input  logic                 row_valid,
  output logic                 row_ready,
  output logic [(N+1)*W-1:0]   row_out,
  output logic                 row_out_valid,
  output logic                 row_fault,
  output logic                 row_corrected,
  output logic [5:0]           corrected_count,
  output logic                 uncorrectable,
  output logic                 done
);

  localparam int CW = $clog2(N + 2);

  logic [2:0]           state_q, state_d;
  logic                 cvr_q;
  logic [N:0]           ind_q;
  logic [(N+1)*W-1:0]   row_q, row_out_q, fixed_row;
  logic [W-1:0]         rowsum_q, rowsum, diff;
  logic [CW-1:0]        row_cnt_q;
  logic [5:0]           count_q;
  logic                 unc_q, fault_q, corr_q;
  logic                 mismatch, single, arm_go;
  logic [6:0]           ncols;

  row_checksum_adder #(.N(N), .W(W)) u_adder (
    .elems_i (row_q[N*W-1:0]),
    .sum_o   (rowsum)
  );

  assign arm_go = column_verify_ready && !cvr_q;

  // Locate a single faulty element from the row mismatch and the latched column flags, and repair it.
  always_comb begin
    diff      = row_q[N*W +: W] - rowsum_q;
    mismatch  = (diff != '0);
    ncols     = popcount(64'(ind_q));
    single    = mismatch && (ncols == 7'd1);
    fixed_row = row_q;
    for (int k = 0; k < N; k++) begin
      if (single && ind_q[k]) fixed_row[k*W +: W] = row_q[k*W +: W] + diff;
    end
    if (single && ind_q[N]) fixed_row[N*W +: W] = rowsum_q;
  end

  // Run sequencing; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (arm_go) state_d = S_ARM;
        S_ARM:      state_d = S_WAIT_ROW;
        S_WAIT_ROW: if (row_valid) state_d = S_SUM;
        S_SUM:      state_d = S_FIX;
        S_FIX:      state_d = S_OUT;
        S_OUT:      state_d = (row_cnt_q == CW'(N)) ? S_DONE : S_WAIT_ROW;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // State register and the registered copy used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cvr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cvr_q   <= column_verify_ready;
    end
  end

  // Datapath and per-run statistics; an aborted cycle leaves everything untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ind_q     <= '0;
      row_q     <= '0;
      rowsum_q  <= '0;
      row_out_q <= '0;
      row_cnt_q <= '0;
      count_q   <= '0;
      unc_q     <= 1'b0;
      fault_q   <= 1'b0;
      corr_q    <= 1'b0;
    end else if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (arm_go) begin
            ind_q     <= column_indicator;
            count_q   <= '0;
            unc_q     <= 1'b0;
            row_cnt_q <= '0;
          end
        end
        S_WAIT_ROW: if (row_valid) row_q <= row_in;
        S_SUM:      rowsum_q <= rowsum;
        S_FIX: begin
          row_out_q <= fixed_row;
          fault_q   <= mismatch;
          corr_q    <= single;
          if (single && count_q != 6'd63) count_q <= count_q + 6'd1;
          if (mismatch && !single) unc_q <= 1'b1;
        end
        S_OUT:      row_cnt_q <= row_cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

  assign row_ready       = (state_q == S_WAIT_ROW);
  assign row_out_valid   = (state_q == S_OUT);
  assign done            = (state_q == S_DONE);
  assign row_out         = row_out_q;
  assign row_fault       = fault_q;
  assign row_corrected   = corr_q;
  assign corrected_count = count_q;
  assign uncorrectable   = unc_q;

endmodule

// File: tb/tb_fault_locate_correct.sv
// tb/tb_fault_locate_correct.sv - directed table-driven bench for fault_locate_correct
module tb_fault_locate_correct;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int RW = (N + 1) * W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N:0]     column_indicator = '0;
  logic           column_verify_ready = 1'b0;
  logic           abort = 1'b0;
  logic [RW-1:0]  row_in = '0;
  logic           row_valid = 1'b0;
  logic           row_ready;
  logic [RW-1:0]  row_out;
  logic           row_out_valid, row_fault, row_corrected, uncorrectable, done;
  logic [5:0]     corrected_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [N:0]   ind;
    int           frow;      // -1 none, 99 every row
    int           fcol;
    logic [W-1:0] delta;
    bit           corr;
    int           exp_count;
    bit           exp_unc;
  } vec_t;

  vec_t tbl[8];

  fault_locate_correct #(.N(N), .W(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .column_indicator    (column_indicator),
    .column_verify_ready (column_verify_ready),
    .abort               (abort),
    .row_in              (row_in),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .row_out             (row_out),
    .row_out_valid       (row_out_valid),
    .row_fault           (row_fault),
    .row_corrected       (row_corrected),
    .corrected_count     (corrected_count),
    .uncorrectable       (uncorrectable),
    .done                (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] true_elem(int r, int c);
    if (r == 0 && c == 0) return 32'hFFFF_FFF0;
    return W'(r) * 32'h0100_0193 + W'(c) * 32'h9E37_79B9 + 32'h0000_0055;
  endfunction

  function automatic logic [RW-1:0] true_row(int r);
    logic [RW-1:0] v;
    logic [W-1:0]  s;
    s = '0;
    v = '0;
    for (int c = 0; c < N; c++) begin
      v[c*W +: W] = true_elem(r, c);
      s = s + true_elem(r, c);
    end
    v[N*W +: W] = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic arm(input logic [N:0] ind);
    @(negedge clk);
    column_indicator = ind;
    column_verify_ready = 1'b1;
    @(negedge clk);
    column_verify_ready = 1'b0;
    chk("arm_count_cleared", RW'(corrected_count), RW'(0));
    chk("arm_unc_cleared", RW'(uncorrectable), RW'(0));
  endtask

  task automatic send_row(input logic [RW-1:0] data, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (row_ready) ok = 1'b1;
    end
    if (!ok) begin
      timeout("row_ready");
      return;
    end
    row_in = data;
    row_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 row_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      if (row_out_valid) ok = 1'b1;
    end
    if (!ok) begin
      timeout("row_out_valid");
      return;
    end
    chk("latency", RW'(cyc - acc), RW'(3));
  endtask

  task automatic run_scenario(input vec_t v, input int idx);
    logic [RW-1:0] tr, din, exp;
    bit            corrupt, ok;
    int            acc;
    arm(v.ind);
    for (int r = 0; r <= N; r++) begin
      corrupt = (v.frow == 99) || (v.frow == r);
      tr  = true_row(r);
      din = tr;
      if (corrupt) din[v.fcol*W +: W] = tr[v.fcol*W +: W] + v.delta;
      exp = (corrupt && v.corr) ? tr : din;
      if (r == 16) begin
        @(negedge clk);
        column_indicator = '1;
        column_verify_ready = 1'b1;
        @(negedge clk);
        column_verify_ready = 1'b0;
        column_indicator = v.ind;
      end
      send_row(din, acc, ok);
      if (!ok) return;
      wait_out(acc, ok);
      if (!ok) return;
      chk($sformatf("s%0d_r%0d_row_out", idx, r), row_out, exp);
      chk($sformatf("s%0d_r%0d_fault", idx, r), RW'(row_fault), RW'(corrupt));
      chk($sformatf("s%0d_r%0d_corrected", idx, r), RW'(row_corrected), RW'(corrupt && v.corr));
    end
    @(negedge clk);
    chk($sformatf("s%0d_done", idx), RW'(done), RW'(1));
    @(negedge clk);
    chk($sformatf("s%0d_done_pulse", idx), RW'(done), RW'(0));
    chk($sformatf("s%0d_count", idx), RW'(corrected_count), RW'(v.exp_count));
    chk($sformatf("s%0d_unc", idx), RW'(uncorrectable), RW'(v.exp_unc));
  endtask

  initial begin
    logic [RW-1:0] din, last;
    bit            ok, seen_v, seen_d;
    int            acc;

    tbl[0] = '{33'h0_0000_0000, -1,  0, 32'h0000_0000, 1'b0,  0, 1'b0};
    tbl[1] = '{33'h0_0000_0020,  7,  5, 32'h0000_0010, 1'b1,  1, 1'b0};
    tbl[2] = '{33'h1_0000_0000,  3, 32, 32'hFFFF_FFFF, 1'b1,  1, 1'b0};
    tbl[3] = '{33'h0_0000_0001,  0,  0, 32'h0000_0015, 1'b1,  1, 1'b0};
    tbl[4] = '{33'h0_0000_0204,  4,  2, 32'h0000_1234, 1'b0,  0, 1'b1};
    tbl[5] = '{33'h0_0000_0204, -1,  0, 32'h0000_0000, 1'b0,  0, 1'b0};
    tbl[6] = '{33'h0_0000_0000, 20,  1, 32'h0000_0007, 1'b0,  0, 1'b1};
    tbl[7] = '{33'h0_0000_0020, 99,  5, 32'h0000_0010, 1'b1, 33, 1'b0};

    #2;
    chk("rst_row_ready", RW'(row_ready), RW'(0));
    chk("rst_row_out_valid", RW'(row_out_valid), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_count", RW'(corrected_count), RW'(0));
    chk("rst_unc", RW'(uncorrectable), RW'(0));
    chk("rst_row_out", row_out, RW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_scenario(tbl[i], i);

    // Abort in FIX of row 10; an ambiguous fault in row 3 leaves uncorrectable set.
    arm(33'h0_0000_0204);
    last = '0;
    for (int r = 0; r <= 10; r++) begin
      din = true_row(r);
      if (r == 3) din[2*W +: W] = din[2*W +: W] + 32'h1;
      send_row(din, acc, ok);
      if (!ok) break;
      if (r == 10) begin
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end else begin
        wait_out(acc, ok);
        if (!ok) break;
        chk($sformatf("abort_r%0d_row_out", r), row_out, din);
        last = din;
      end
    end
    seen_v = 1'b0;
    seen_d = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (row_out_valid) seen_v = 1'b1;
      if (done) seen_d = 1'b1;
    end
    chk("abort_no_row_out_valid", RW'(seen_v), RW'(0));
    chk("abort_no_done", RW'(seen_d), RW'(0));
    chk("abort_idle_not_ready", RW'(row_ready), RW'(0));
    chk("abort_unc_kept", RW'(uncorrectable), RW'(1));
    chk("abort_count_kept", RW'(corrected_count), RW'(0));
    chk("abort_row_out_held", row_out, last);

    // Asynchronous reset in the middle of SUM.
    arm(33'h0_0000_0000);
    send_row(true_row(0), acc, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_row_out", row_out, RW'(0));
    chk("mid_rst_row_out_valid", RW'(row_out_valid), RW'(0));
    chk("mid_rst_done", RW'(done), RW'(0));
    chk("mid_rst_row_ready", RW'(row_ready), RW'(0));
    chk("mid_rst_fault", RW'(row_fault), RW'(0));
    chk("mid_rst_count", RW'(corrected_count), RW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", RW'(row_ready | row_out_valid | done), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
